// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - fixed-priority SDRAM command bus arbiter (refresh > write > read)
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        ref_req,
  input  logic        ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t state;

  // Grants are registered alongside the state change so they mark the first owned cycle.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state  <= S_INIT;
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
    end else begin
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_done) state <= S_ARBIT;
        end
        S_ARBIT: begin
          if (ref_req) begin
            state  <= S_AREF;
            ref_en <= 1'b1;
          end else if (wr_req) begin
            state <= S_WRITE;
            wr_en <= 1'b1;
          end else if (rd_req) begin
            state <= S_READ;
            rd_en <= 1'b1;
          end
        end
        S_AREF: begin
          if (ref_end) state <= S_ARBIT;
        end
        S_WRITE: begin
          if (wr_end) state <= S_ARBIT;
        end
        S_READ: begin
          if (rd_end) state <= S_ARBIT;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = 12'd0;
    sdram_bank = 2'b00;
    case (state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 12'd0;
        sdram_bank = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed and randomized checks for sdram_arbit
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        ref_req, ref_end;
  logic [3:0]  ref_cmd;
  logic [11:0] ref_addr;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        ref_en, wr_en, rd_en;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  int total = 0;
  int bad = 0;

  localparam logic [3:0] NOP = 4'b0111;

  always #5 sclk = ~sclk;

  sdram_arbit dut (
    .sclk(sclk), .rst_n(rst_n), .init_done(init_done),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank)
  );

  // One clock edge; inputs are driven and outputs sampled on the falling edge.
  task automatic cyc();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b0;
    cyc();
    total++;
    if (sdram_cmd !== 4'b0010 || sdram_addr !== 12'h111 || sdram_bank !== 2'b00 ||
        {ref_en, wr_en, rd_en} !== 3'b000) begin
      bad++;
      $display("FAIL reset_state: cmd=%b addr=%h bank=%b en=%b required cmd=0010 addr=111 bank=00 en=000",
               sdram_cmd, sdram_addr, sdram_bank, {ref_en, wr_en, rd_en});
    end
    rst_n = 1'b1;
    ref_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      total++;
      if (sdram_cmd !== 4'b0010 || {ref_en, wr_en, rd_en} !== 3'b000) begin
        bad++;
        $display("FAIL init_hold[%0d]: cmd=%b en=%b required cmd=0010 en=000",
                 i, sdram_cmd, {ref_en, wr_en, rd_en});
      end
    end
    ref_req = 1'b0;
    init_done = 1'b1;
    cyc();
    total++;
    if (sdram_cmd !== NOP || sdram_addr !== 12'd0 || sdram_bank !== 2'b00) begin
      bad++;
      $display("FAIL init_to_arbit: cmd=%b addr=%h bank=%b required cmd=0111 addr=000 bank=00",
               sdram_cmd, sdram_addr, sdram_bank);
    end
    init_done = 1'b0;
    cyc();
    total++;
    if (sdram_cmd !== NOP) begin
      bad++;
      $display("FAIL init_done_ignored: cmd=%b required 0111", sdram_cmd);
    end
  endtask

  task automatic test_priority();
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    cyc();
    total++;
    if ({ref_en, wr_en, rd_en} !== 3'b100 || sdram_cmd !== 4'b0001 || sdram_addr !== 12'h222) begin
      bad++;
      $display("FAIL prio_ref_grant: en=%b cmd=%b addr=%h required en=100 cmd=0001 addr=222",
               {ref_en, wr_en, rd_en}, sdram_cmd, sdram_addr);
    end
    ref_req = 1'b0;
    cyc();
    total++;
    if ({ref_en, wr_en, rd_en} !== 3'b000 || sdram_cmd !== 4'b0001) begin
      bad++;
      $display("FAIL prio_ref_width: en=%b cmd=%b required en=000 cmd=0001",
               {ref_en, wr_en, rd_en}, sdram_cmd);
    end
    ref_end = 1'b1;
    cyc();
    ref_end = 1'b0;
    total++;
    if ({ref_en, wr_en, rd_en} !== 3'b000 || sdram_cmd !== NOP) begin
      bad++;
      $display("FAIL prio_ref_return: en=%b cmd=%b required en=000 cmd=0111",
               {ref_en, wr_en, rd_en}, sdram_cmd);
    end
    cyc();
    total++;
    if ({ref_en, wr_en, rd_en} !== 3'b010 || sdram_cmd !== 4'b0100) begin
      bad++;
      $display("FAIL prio_wr_grant: en=%b cmd=%b required en=010 cmd=0100",
               {ref_en, wr_en, rd_en}, sdram_cmd);
    end
    wr_req = 1'b0;
    cyc();
    total++;
    if (sdram_addr !== 12'h0A5 || sdram_bank !== 2'b10 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL wr_mux: addr=%h bank=%b wr_en=%b required addr=0a5 bank=10 wr_en=0",
               sdram_addr, sdram_bank, wr_en);
    end
    rd_end = 1'b1;
    cyc();
    rd_end = 1'b0;
    total++;
    if (sdram_cmd !== 4'b0100 || {ref_en, wr_en, rd_en} !== 3'b000) begin
      bad++;
      $display("FAIL foreign_end_ignored: cmd=%b en=%b required cmd=0100 en=000",
               sdram_cmd, {ref_en, wr_en, rd_en});
    end
    wr_end = 1'b1;
    cyc();
    wr_end = 1'b0;
    total++;
    if (sdram_cmd !== NOP || sdram_bank !== 2'b00) begin
      bad++;
      $display("FAIL wr_return: cmd=%b bank=%b required cmd=0111 bank=00", sdram_cmd, sdram_bank);
    end
    cyc();
    total++;
    if ({ref_en, wr_en, rd_en} !== 3'b001 || sdram_cmd !== 4'b0101 ||
        sdram_addr !== 12'h3C3 || sdram_bank !== 2'b01) begin
      bad++;
      $display("FAIL prio_rd_grant: en=%b cmd=%b addr=%h bank=%b required en=001 cmd=0101 addr=3c3 bank=01",
               {ref_en, wr_en, rd_en}, sdram_cmd, sdram_addr, sdram_bank);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_ref_during_read();
    ref_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (ref_en !== 1'b0 || sdram_cmd !== 4'b0101) begin
        bad++;
        $display("FAIL no_preempt[%0d]: ref_en=%b cmd=%b required ref_en=0 cmd=0101", i, ref_en, sdram_cmd);
      end
    end
    rd_end = 1'b1;
    cyc();
    rd_end = 1'b0;
    total++;
    if (ref_en !== 1'b0 || sdram_cmd !== NOP) begin
      bad++;
      $display("FAIL rd_end_gap: ref_en=%b cmd=%b required ref_en=0 cmd=0111", ref_en, sdram_cmd);
    end
    cyc();
    total++;
    if (ref_en !== 1'b1 || sdram_cmd !== 4'b0001) begin
      bad++;
      $display("FAIL ref_after_rd: ref_en=%b cmd=%b required ref_en=1 cmd=0001", ref_en, sdram_cmd);
    end
    ref_end = 1'b1;
    cyc();
    ref_end = 1'b0;
    total++;
    if (ref_en !== 1'b0 || sdram_cmd !== NOP) begin
      bad++;
      $display("FAIL ref_end_req_arbit: ref_en=%b cmd=%b required ref_en=0 cmd=0111", ref_en, sdram_cmd);
    end
    cyc();
    total++;
    if (ref_en !== 1'b1 || sdram_cmd !== 4'b0001) begin
      bad++;
      $display("FAIL ref_regrant: ref_en=%b cmd=%b required ref_en=1 cmd=0001", ref_en, sdram_cmd);
    end
    ref_req = 1'b0;
    ref_end = 1'b1;
    cyc();
    ref_end = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    wr_req = 1'b1;
    cyc();
    total++;
    if (wr_en !== 1'b1) begin
      bad++;
      $display("FAIL rmw_grant: wr_en=%b required 1", wr_en);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    total++;
    if (wr_en !== 1'b0 || sdram_cmd !== 4'b0010 || sdram_addr !== 12'h111) begin
      bad++;
      $display("FAIL rmw_abort: wr_en=%b cmd=%b addr=%h required wr_en=0 cmd=0010 addr=111",
               wr_en, sdram_cmd, sdram_addr);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if ({ref_en, wr_en, rd_en} !== 3'b000 || sdram_cmd !== 4'b0010) begin
        bad++;
        $display("FAIL rmw_wait_init[%0d]: en=%b cmd=%b required en=000 cmd=0010",
                 i, {ref_en, wr_en, rd_en}, sdram_cmd);
      end
    end
    init_done = 1'b1;
    cyc();
    init_done = 1'b0;
    total++;
    if (wr_en !== 1'b0 || sdram_cmd !== NOP) begin
      bad++;
      $display("FAIL rmw_arbit: wr_en=%b cmd=%b required wr_en=0 cmd=0111", wr_en, sdram_cmd);
    end
    cyc();
    wr_req = 1'b0;
    total++;
    if (wr_en !== 1'b1 || sdram_cmd !== 4'b0100) begin
      bad++;
      $display("FAIL rmw_regrant: wr_en=%b cmd=%b required wr_en=1 cmd=0100", wr_en, sdram_cmd);
    end
    wr_end = 1'b1;
    cyc();
    wr_end = 1'b0;
  endtask

  task automatic test_random();
    int ms;
    logic [2:0] een;
    logic [3:0] ecmd;
    logic [11:0] eaddr;
    logic [1:0] ebank;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    ms = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ref_req) ref_req = ($urandom_range(0, 7) == 0);
      if (!wr_req)  wr_req  = ($urandom_range(0, 4) == 0);
      if (!rd_req)  rd_req  = ($urandom_range(0, 4) == 0);
      ref_end   = ($urandom_range(0, 3) == 0);
      wr_end    = ($urandom_range(0, 3) == 0);
      rd_end    = ($urandom_range(0, 3) == 0);
      init_done = ($urandom_range(0, 2) == 0);
      init_cmd = 4'($urandom); ref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
      init_addr = 12'($urandom); ref_addr = 12'($urandom);
      wr_addr = 12'($urandom); rd_addr = 12'($urandom);
      wr_bank = 2'($urandom); rd_bank = 2'($urandom);
      een = 3'b000;
      case (ms)
        0: if (init_done) ms = 1;
        1: if (ref_req) begin ms = 2; een = 3'b100; end
           else if (wr_req) begin ms = 3; een = 3'b010; end
           else if (rd_req) begin ms = 4; een = 3'b001; end
        2: if (ref_end) ms = 1;
        3: if (wr_end) ms = 1;
        default: if (rd_end) ms = 1;
      endcase
      case (ms)
        0: begin ecmd = init_cmd; eaddr = init_addr; ebank = 2'b00; end
        1: begin ecmd = NOP; eaddr = 12'd0; ebank = 2'b00; end
        2: begin ecmd = ref_cmd; eaddr = ref_addr; ebank = 2'b00; end
        3: begin ecmd = wr_cmd; eaddr = wr_addr; ebank = wr_bank; end
        default: begin ecmd = rd_cmd; eaddr = rd_addr; ebank = rd_bank; end
      endcase
      cyc();
      total++;
      if ({ref_en, wr_en, rd_en} !== een || sdram_cmd !== ecmd ||
          sdram_addr !== eaddr || sdram_bank !== ebank) begin
        bad++;
        $display("FAIL random[%0d]: en=%b cmd=%b addr=%h bank=%b required en=%b cmd=%b addr=%h bank=%b",
                 i, {ref_en, wr_en, rd_en}, sdram_cmd, sdram_addr, sdram_bank, een, ecmd, eaddr, ebank);
      end
      if (ref_en) ref_req = 1'b0;
      if (wr_en)  wr_req  = 1'b0;
      if (rd_en)  rd_req  = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0;
    init_cmd = 4'b0010; init_addr = 12'h111;
    ref_req = 1'b0; ref_end = 1'b0; ref_cmd = 4'b0001; ref_addr = 12'h222;
    wr_req = 1'b0; wr_end = 1'b0; wr_cmd = 4'b0100; wr_addr = 12'h0A5; wr_bank = 2'b10;
    rd_req = 1'b0; rd_end = 1'b0; rd_cmd = 4'b0101; rd_addr = 12'h3C3; rd_bank = 2'b01;
    @(negedge sclk);
    test_reset();
    test_priority();
    test_ref_during_read();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
